// File: rtl/sid_dac_pkg.sv
// Shared types and constants for the SID DAC serializer.
// A frame is a 4-bit MCP4922 header followed by a 12-bit sample, sent MSB first.
package sid_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_CS_HOLD,
        ST_LATCH
    } dac_state_e;

    localparam int FRAME_BITS     = 16;
    localparam int SAMPLE_BITS    = 12;
    localparam int HDR_AB         = 15;
    localparam int HDR_BUF        = 14;
    localparam int HDR_GA         = 13;
    localparam int HDR_SHDN       = 12;
    localparam int TICKS_PER_CHAN = 34;

    typedef logic [FRAME_BITS-1:0]  frame_t;
    typedef logic [SAMPLE_BITS-1:0] sample_t;

    // Gain is fixed at 1x (GAb=1) and the output is always active (SHDNb=1).
    function automatic frame_t build_frame(input logic chan_b, input logic buf_bit, input sample_t s);
        frame_t f;
        f                  = '0;
        f[SAMPLE_BITS-1:0] = s;
        f[HDR_AB]          = chan_b;
        f[HDR_BUF]         = buf_bit;
        f[HDR_GA]          = 1'b1;
        f[HDR_SHDN]        = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/sid_dac_if.sv
// Sample input and DAC pin bundle between the SID mixer and the serializer.
interface sid_dac_if;
    import sid_dac_pkg::*;

    sample_t sample_1_i;
    sample_t sample_2_i;
    sample_t sample_3_i;
    logic    sample_valid_i;
    logic    dac_clk_o;
    logic    dac_dat_1_o;
    logic    dac_dat_2_o;
    logic    dac_csb_o;
    logic    dac_leb_o;
    logic    busy_o;
    logic    done_o;
    logic    overrun_o;

    modport slave (
        input  sample_1_i, sample_2_i, sample_3_i, sample_valid_i,
        output dac_clk_o, dac_dat_1_o, dac_dat_2_o, dac_csb_o, dac_leb_o,
        output busy_o, done_o, overrun_o
    );

    modport master (
        output sample_1_i, sample_2_i, sample_3_i, sample_valid_i,
        input  dac_clk_o, dac_dat_1_o, dac_dat_2_o, dac_csb_o, dac_leb_o,
        input  busy_o, done_o, overrun_o
    );

endinterface

// File: rtl/sid_dac_tick.sv
// Serial-timing enable: one-cycle pulse every CLK_DIV clocks, re-phased by i_restart.
module sid_dac_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);
    import sid_dac_pkg::*;

    localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= RELOAD;
        end else if (i_restart || (r_cnt == '0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/sid_dac_serializer.sv
// Streams three SID voice samples to two MCP4922 DACs sharing SCK, CSb and LDACb.
// Channel A carries samples 1/2, channel B carries sample 3 on both DACs.
module sid_dac_serializer #(
    parameter int CLK_DIV  = 4,
    parameter bit VREF_BUF = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    sid_dac_if.slave   bus
);
    import sid_dac_pkg::*;

    dac_state_e r_state;
    sample_t    r_slot   [3];
    sample_t    r_shadow [3];
    sample_t    w_samp_in [3];
    logic       r_slot_full;
    logic       r_overrun;
    logic       r_chan_b;
    logic [3:0] r_bit;
    logic       r_dac_clk, r_dat_1, r_dat_2, r_csb, r_leb, r_busy, r_done;

    logic       w_tick;
    logic       w_consume;
    logic [3:0] w_bit_nxt;
    frame_t     w_frm_a_1, w_frm_a_2, w_frm_b, w_cur_1, w_cur_2;

    assign w_samp_in[0] = bus.sample_1_i;
    assign w_samp_in[1] = bus.sample_2_i;
    assign w_samp_in[2] = bus.sample_3_i;

    assign w_consume = (r_state == ST_IDLE) && r_slot_full;
    assign w_bit_nxt = r_bit - 4'd1;

    assign w_frm_a_1 = build_frame(1'b0, VREF_BUF, r_shadow[0]);
    assign w_frm_a_2 = build_frame(1'b0, VREF_BUF, r_shadow[1]);
    assign w_frm_b   = build_frame(1'b1, VREF_BUF, r_shadow[2]);
    assign w_cur_1   = r_chan_b ? w_frm_b : w_frm_a_1;
    assign w_cur_2   = r_chan_b ? w_frm_b : w_frm_a_2;

    sid_dac_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_restart (w_consume),
        .o_tick    (w_tick)
    );

    // Slot data keeps following strobes; the shadow copy freezes at frame start.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_samp
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_slot[gi]   <= '0;
                    r_shadow[gi] <= '0;
                end else begin
                    if (bus.sample_valid_i) r_slot[gi]   <= w_samp_in[gi];
                    if (w_consume)          r_shadow[gi] <= r_slot[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_slot_full <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (bus.sample_valid_i) begin
            r_slot_full <= 1'b1;
            if (r_slot_full && !w_consume) r_overrun <= 1'b1;
        end else if (w_consume) begin
            r_slot_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_chan_b  <= 1'b0;
            r_bit     <= 4'd15;
            r_dac_clk <= 1'b0;
            r_dat_1   <= 1'b0;
            r_dat_2   <= 1'b0;
            r_csb     <= 1'b1;
            r_leb     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_slot_full) begin
                        r_busy   <= 1'b1;
                        r_chan_b <= 1'b0;
                        r_bit    <= 4'd15;
                        r_csb    <= 1'b0;
                        // A/Bb is the first bit out and is 0 for channel A.
                        r_dat_1  <= 1'b0;
                        r_dat_2  <= 1'b0;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_dat_1 <= w_cur_1[r_bit];
                        r_dat_2 <= w_cur_2[r_bit];
                        r_state <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_tick) begin
                        r_dac_clk <= 1'b1;
                        r_state   <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_tick) begin
                        r_dac_clk <= 1'b0;
                        if (r_bit == 4'd0) begin
                            r_csb   <= 1'b1;
                            r_dat_1 <= 1'b0;
                            r_dat_2 <= 1'b0;
                            r_state <= ST_CS_HOLD;
                        end else begin
                            r_bit   <= w_bit_nxt;
                            r_dat_1 <= w_cur_1[w_bit_nxt];
                            r_dat_2 <= w_cur_2[w_bit_nxt];
                            r_state <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_CS_HOLD: begin
                    if (w_tick) begin
                        if (!r_chan_b) begin
                            r_chan_b <= 1'b1;
                            r_bit    <= 4'd15;
                            r_csb    <= 1'b0;
                            r_dat_1  <= w_frm_b[FRAME_BITS-1];
                            r_dat_2  <= w_frm_b[FRAME_BITS-1];
                            r_state  <= ST_SETUP;
                        end else begin
                            r_leb   <= 1'b0;
                            r_state <= ST_LATCH;
                        end
                    end
                end
                ST_LATCH: begin
                    if (w_tick) begin
                        r_leb   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dac_clk_o   = r_dac_clk;
    assign bus.dac_dat_1_o = r_dat_1;
    assign bus.dac_dat_2_o = r_dat_2;
    assign bus.dac_csb_o   = r_csb;
    assign bus.dac_leb_o   = r_leb;
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.overrun_o   = r_overrun;

endmodule

// File: tb/tb_sid_dac_serializer.sv
// Bench for sid_dac_serializer: DUT0 (CLK_DIV=4, BUF=0) and DUT1 (CLK_DIV=1, BUF=1)
// checked every cycle against a frame-timeline model, plus serial receivers and directed literals.
module tb_sid_dac_serializer;
    import sid_dac_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        vld [2];
    logic [11:0] s1 [2];
    logic [11:0] s2 [2];
    logic [11:0] s3 [2];
    logic [7:0]  outv [2];   // {clk, dat1, dat2, csb, leb, busy, done, overrun}

    sid_dac_if bus0 ();
    sid_dac_if bus1 ();

    assign bus0.sample_1_i     = s1[0];
    assign bus0.sample_2_i     = s2[0];
    assign bus0.sample_3_i     = s3[0];
    assign bus0.sample_valid_i = vld[0];
    assign bus1.sample_1_i     = s1[1];
    assign bus1.sample_2_i     = s2[1];
    assign bus1.sample_3_i     = s3[1];
    assign bus1.sample_valid_i = vld[1];

    assign outv[0] = {bus0.dac_clk_o, bus0.dac_dat_1_o, bus0.dac_dat_2_o, bus0.dac_csb_o,
                      bus0.dac_leb_o, bus0.busy_o, bus0.done_o, bus0.overrun_o};
    assign outv[1] = {bus1.dac_clk_o, bus1.dac_dat_1_o, bus1.dac_dat_2_o, bus1.dac_csb_o,
                      bus1.dac_leb_o, bus1.busy_o, bus1.done_o, bus1.overrun_o};

    sid_dac_serializer #(.CLK_DIV(4), .VREF_BUF(1'b0)) u_dut0 (.clk_i(clk), .rst_i(rst[0]), .bus(bus0));
    sid_dac_serializer #(.CLK_DIV(1), .VREF_BUF(1'b1)) u_dut1 (.clk_i(clk), .rst_i(rst[1]), .bus(bus1));

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic bit vref_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    // Model: slot plus a frame timeline position t (1 = first cycle after the start edge).
    int          m_t    [2];
    bit          m_act  [2];
    bit          m_done [2];
    bit          m_full [2];
    bit          m_ovr  [2];
    logic [11:0] m_s1 [2], m_s2 [2], m_s3 [2];
    logic [15:0] m_w1a [2], m_w2a [2], m_wb [2];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_act[i] = 0; m_t[i] = 0; m_full[i] = 0; m_ovr[i] = 0; m_done[i] = 0;
            end else begin
                bit consume;
                consume   = !m_act[i] && m_full[i];
                m_done[i] = 0;
                if (m_act[i]) begin
                    m_t[i]++;
                    if (m_t[i] > (2 * TICKS_PER_CHAN + 1) * div_of(i)) begin
                        m_act[i]  = 0;
                        m_done[i] = 1;
                    end
                end else if (consume) begin
                    m_act[i] = 1;
                    m_t[i]   = 1;
                    m_w1a[i] = 16'h3000 | (vref_of(i) ? 16'h4000 : 16'h0000) | {4'h0, m_s1[i]};
                    m_w2a[i] = 16'h3000 | (vref_of(i) ? 16'h4000 : 16'h0000) | {4'h0, m_s2[i]};
                    m_wb[i]  = 16'hB000 | (vref_of(i) ? 16'h4000 : 16'h0000) | {4'h0, m_s3[i]};
                end
                if (vld[i]) begin
                    if (m_full[i] && !consume) m_ovr[i] = 1;
                    m_s1[i] = s1[i]; m_s2[i] = s2[i]; m_s3[i] = s3[i];
                    m_full[i] = 1;
                end else if (consume) begin
                    m_full[i] = 0;
                end
            end
        end
    end

    function automatic logic [7:0] exp_out(input int i);
        int k, c, j, b;
        logic [15:0] w1, w2;
        if (!m_act[i]) return {6'b000110, m_done[i], m_ovr[i]};
        k = (m_t[i] - 1) / div_of(i);
        if (k == 2 * TICKS_PER_CHAN) return {7'b0001010, m_ovr[i]};
        c  = k / TICKS_PER_CHAN;
        j  = k % TICKS_PER_CHAN;
        w1 = (c != 0) ? m_wb[i] : m_w1a[i];
        w2 = (c != 0) ? m_wb[i] : m_w2a[i];
        if (j == 0) return {1'b0, w1[15], w2[15], 4'b0110, m_ovr[i]};
        if (j == TICKS_PER_CHAN - 1) return {7'b0001110, m_ovr[i]};
        b = 15 - (j - 1) / 2;
        return {((j - 1) % 2 == 1), w1[b], w2[b], 4'b0110, m_ovr[i]};
    endfunction

    // Receivers and protocol watch, sampled on the falling edge.
    logic [7:0]  prev [2];
    logic [15:0] sh1 [2], sh2 [2];
    int          edges [2];
    logic [15:0] rx1 [2][8];
    logic [15:0] rx2 [2][8];
    int          rx_edges [2][8];
    int          rx_cnt [2];
    int          leb_run [2], leb_w [2], leb_pulses [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            prev[i] = 8'h18; sh1[i] = '0; sh2[i] = '0; edges[i] = 0; rx_cnt[i] = 0;
            leb_run[i] = 0; leb_w[i] = 0; leb_pulses[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] o, e, p;
            o = outv[i];
            p = prev[i];
            e = exp_out(i);
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL model_cmp dut%0d cyc %0d: got %b want %b", i, cyc, o, e);
            end
            if (o[7]) begin
                vectors++;
                if (o[6:4] !== p[6:4]) begin
                    errors++;
                    $display("FAIL proto_clk_high dut%0d cyc %0d: dat/csb %b was %b", i, cyc, o[6:4], p[6:4]);
                end
            end
            if (!o[3]) begin
                vectors++;
                if (o[4] !== 1'b1) begin
                    errors++;
                    $display("FAIL proto_leb_csb dut%0d cyc %0d: csb %b want 1", i, cyc, o[4]);
                end
            end
            if (o[7] && !p[7] && !o[4]) begin
                sh1[i] = {sh1[i][14:0], o[6]};
                sh2[i] = {sh2[i][14:0], o[5]};
                edges[i]++;
            end
            if (o[4] && !p[4]) begin
                if (rx_cnt[i] < 8) begin
                    rx1[i][rx_cnt[i]]      = sh1[i];
                    rx2[i][rx_cnt[i]]      = sh2[i];
                    rx_edges[i][rx_cnt[i]] = edges[i];
                end
                rx_cnt[i]++;
                edges[i] = 0;
            end
            if (!o[3]) begin
                leb_run[i]++;
            end else if (leb_run[i] > 0) begin
                leb_w[i] = leb_run[i];
                leb_pulses[i]++;
                leb_run[i] = 0;
            end
            prev[i] = o;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic strobe(input int i, input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        @(negedge clk);
        s1[i] = a; s2[i] = b; s3[i] = c; vld[i] = 1'b1;
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (outv[i][1] === 1'b1) begin
                n = k;
                break;
            end
        end
        if (n < 0) begin
            vectors++;
            errors++;
            $display("FAIL wait_done dut%0d: no done_o within %0d cycles", i, budget);
        end
    endtask

    initial begin
        int n;
        int busy_seen;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; vld[i] = 1'b0; s1[i] = '0; s2[i] = '0; s3[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset_state_dut0", 32'(outv[0]), 32'h18);
        chk("reset_state_dut1", 32'(outv[1]), 32'h18);
        rst[0] = 1'b0; rst[1] = 1'b0;
        repeat (3) @(negedge clk);

        // Single frame, CLK_DIV=4
        rx_cnt[0] = 0; leb_pulses[0] = 0;
        strobe(0, 12'hABC, 12'h123, 12'h800);
        wait_done(0, 400, n);
        chk("t1_done_cycle", 32'(n), 32'd277);
        @(negedge clk);
        chk("t1_word_count", 32'(rx_cnt[0]), 32'd2);
        chk("t1_dac1_a", 32'(rx1[0][0]), 32'h3ABC);
        chk("t1_dac1_b", 32'(rx1[0][1]), 32'hB800);
        chk("t1_dac2_a", 32'(rx2[0][0]), 32'h3123);
        chk("t1_dac2_b", 32'(rx2[0][1]), 32'hB800);
        chk("t1_edges_a", 32'(rx_edges[0][0]), 32'd16);
        chk("t1_edges_b", 32'(rx_edges[0][1]), 32'd16);
        chk("t1_leb_pulses", 32'(leb_pulses[0]), 32'd1);
        chk("t1_leb_width", 32'(leb_w[0]), 32'd4);

        // VREF_BUF=1, CLK_DIV=1
        rx_cnt[1] = 0;
        strobe(1, 12'hFFF, 12'hFFF, 12'hFFF);
        wait_done(1, 200, n);
        chk("t2_frame_len", 32'(n), 32'd70);
        @(negedge clk);
        chk("t2_dac1_a", 32'(rx1[1][0]), 32'h7FFF);
        chk("t2_dac1_b", 32'(rx1[1][1]), 32'hFFFF);
        chk("t2_dac2_a", 32'(rx2[1][0]), 32'h7FFF);

        // Back-to-back
        rx_cnt[0] = 0;
        strobe(0, 12'h111, 12'h222, 12'h333);
        repeat (100) @(negedge clk);
        strobe(0, 12'h444, 12'h555, 12'h666);
        wait_done(0, 400, n);
        @(negedge clk);
        chk("t3_restart_busy", 32'(outv[0][2]), 32'd1);
        chk("t3_no_overrun", 32'(outv[0][0]), 32'd0);
        wait_done(0, 400, n);
        chk("t3_second_len", 32'(n), 32'd276);
        @(negedge clk);
        chk("t3_dac1_a2", 32'(rx1[0][2]), 32'h3444);
        chk("t3_dac1_b2", 32'(rx1[0][3]), 32'hB666);
        chk("t3_dac2_a2", 32'(rx2[0][2]), 32'h3555);

        // Overrun: three strobes within one frame
        rx_cnt[0] = 0;
        strobe(0, 12'hAAA, 12'hBBB, 12'hCCC);
        repeat (40) @(negedge clk);
        strobe(0, 12'h001, 12'h002, 12'h003);
        chk("t4_ovr_after2", 32'(outv[0][0]), 32'd0);
        repeat (40) @(negedge clk);
        strobe(0, 12'h0DE, 12'h0AD, 12'h0BE);
        chk("t4_ovr_after3", 32'(outv[0][0]), 32'd1);
        wait_done(0, 400, n);
        wait_done(0, 400, n);
        @(negedge clk);
        chk("t4_dac1_a2", 32'(rx1[0][2]), 32'h30DE);
        chk("t4_dac2_a2", 32'(rx2[0][2]), 32'h30AD);
        chk("t4_dac1_b2", 32'(rx1[0][3]), 32'hB0BE);
        chk("t4_ovr_sticky", 32'(outv[0][0]), 32'd1);

        // Reset at bit 7 of channel B with a pending sample set
        @(negedge clk); rst[0] = 1'b1;
        @(negedge clk); rst[0] = 1'b0;
        chk("t5_ovr_cleared", 32'(outv[0][0]), 32'd0);
        leb_pulses[0] = 0;
        strobe(0, 12'h0F0, 12'h0A5, 12'h5A5);
        @(negedge clk);
        chk("t5_setup_dut", 32'(outv[0]), 32'h0C);
        chk("t5_setup_model", 32'(exp_out(0)), 32'h0C);
        strobe(0, 12'h111, 12'h111, 12'h111);
        repeat (204) @(negedge clk);
        chk("t5_bit7_dut", 32'(outv[0]), 32'h6C);
        chk("t5_bit7_model", 32'(exp_out(0)), 32'h6C);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("t5_after_reset", 32'(outv[0]), 32'h18);
        busy_seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (outv[0][2] === 1'b1) busy_seen = 1;
        end
        chk("t5_slot_empty", 32'(busy_seen), 32'd0);
        chk("t5_no_ldac", 32'(leb_pulses[0]), 32'd0);

        // Randomized strobes; model and protocol watch run throughout
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 199) == 0) begin
                    vld[i] = 1'b1;
                    s1[i]  = 12'($urandom);
                    s2[i]  = 12'($urandom);
                    s3[i]  = 12'($urandom);
                end else begin
                    vld[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
        vld[0] = 1'b0; vld[1] = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
